writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of result data.
REQ-002 Parameter REG_BITS, default 5, register address width.
REQ-003 Parameter NUM_FU, default 4, number of functional units; legal range 2..8.
REQ-004 Parameter FU_BITS, default 2, FU index width, equal to ceil(log2(NUM_FU)).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 fu_valid  input  NUM_FU  per-FU result-available request.
REQ-008 fu_ready  output  NUM_FU  per-FU result-accepted indication.
REQ-009 fu_dest  input  NUM_FU*REG_BITS  flattened destination registers; FU i occupies bits [i*REG_BITS +: REG_BITS].
REQ-010 fu_data  input  NUM_FU*DATA_WIDTH  flattened result data; FU i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 wb_block  input  NUM_FU  scoreboard WAR hold; a set bit makes that FU ineligible for grant.
REQ-012 write_en  output  1  register-file write strobe.
REQ-013 write_addr  output  REG_BITS  register-file write address.
REQ-014 write_data  output  DATA_WIDTH  register-file write data.
REQ-015 wb_done  output  1  one-cycle pulse per completed writeback, including writebacks to r0.
REQ-016 wb_fu_id  output  FU_BITS  index of the FU whose writeback completes; valid while wb_done=1.

Function
REQ-017 Each FU SHALL have a one-entry holding slot (pending bit, dest, data); fu_ready[i] = ~pending[i], with no combinational path from fu_valid.
REQ-018 fu_valid[i] & fu_ready[i] at a rising edge SHALL capture fu_dest/fu_data for FU i and set pending[i].
REQ-019 Each cycle the arbiter SHALL grant one FU among pending & ~wb_block, using round-robin order starting at pointer rr_ptr.
REQ-020 On a grant to FU g, the next edge SHALL clear pending[g] and set rr_ptr = (g+1) mod NUM_FU.
REQ-021 With no grant, rr_ptr SHALL hold.
REQ-022 On a grant, the next edge SHALL register wb_done=1, wb_fu_id=g, write_addr=dest[g], write_data=data[g], write_en=(dest[g]!=0).
REQ-023 With no grant, wb_done and write_en SHALL be 0 in the next cycle; write_addr, write_data and wb_fu_id SHALL hold.
REQ-024 Latency SHALL be exactly 2 edges from the accepting edge to write_en/wb_done high, for an unblocked, uncontended FU.
REQ-025 Sustained throughput SHALL be one writeback per cycle; fu_ready[g] SHALL be high the cycle after FU g is granted.
REQ-026 A write to r0 SHALL still consume a grant, clear its slot and pulse wb_done, with write_en=0.
REQ-027 wb_block SHALL NOT affect capture; a blocked pending slot SHALL remain intact indefinitely.
REQ-028 Identical destinations from two FUs SHALL NOT be checked; the writes occur in grant order.
REQ-029 Capture and grant of different FUs in the same cycle SHALL both take effect.

Reset
REQ-030 rst_n low SHALL immediately clear all pending bits and set rr_ptr=0, write_en=0, wb_done=0, write_addr=0, write_data=0, wb_fu_id=0; fu_ready therefore reads all ones.
REQ-031 Reset mid-operation SHALL discard all held results without issuing any write; no write_en pulse SHALL follow reset release until a new capture occurs.

Structure
REQ-032 DATA_WIDTH, REG_BITS, NUM_FU and FU_BITS defaults SHALL live in the shared scoreboard parameter package, alongside the register_file parameters.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs req, ptr; outputs grant_valid, grant_idx).
REQ-034 write_addr/write_data/write_en SHALL connect directly to the register_file write port.

Verification
REQ-035 Single result: FU1 presents dest=7, data=0xDEADBEEF at edge 0 -> write_en=1, write_addr=7, write_data=0xDEADBEEF, wb_fu_id=1 after edge 2; register 7 reads 0xDEADBEEF.
REQ-036 Contention: FU0..FU3 all valid in the same cycle, rr_ptr=0 -> grants 0,1,2,3 on consecutive cycles; fu_ready[0] is high again after the first grant.
REQ-037 Fairness: FU0 and FU2 continuously valid -> writebacks alternate 0,2,0,2 with no starvation.
REQ-038 Block: FU3 pending with wb_block[3]=1 for 5 cycles -> no write; after release -> write within 1 edge, data intact.
REQ-039 r0: FU2 with dest=0, data=0x55 -> wb_done=1, wb_fu_id=2, write_en=0; register 0 still reads 0.
REQ-040 Reset: rst_n asserted while 3 slots are pending -> all outputs 0 and fu_ready=all ones immediately; no write after release.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared scoreboard parameters for the writeback path and register file.
// Holds width/count defaults plus the round-robin wrap helper.
package writeback_arbiter_pkg;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_REG_BITS   = 5;
   localparam int WB_NUM_FU     = 4;
   localparam int WB_FU_BITS    = 2;

   localparam int RF_DEPTH      = 1 << WB_REG_BITS;
   localparam int RF_READ_PORTS = 2;

   // Modulo for a value known to be below 2*n.
   function automatic int rr_wrap(input int v, input int n);
      return (v >= n) ? (v - n) : v;
   endfunction
endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int IDX_BITS = 2
) (
   input  logic [N-1:0]        req,
   input  logic [IDX_BITS-1:0] ptr,
   output logic                grant_valid,
   output logic [IDX_BITS-1:0] grant_idx
);

   int idx;

   // Scan from farthest to nearest so the closest requester to ptr wins last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = rr_wrap(int'(ptr) + k, N);
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_BITS'(idx);
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Per-FU one-entry result slots arbitrated round-robin onto one register-file write port.
// Accept edge plus one edge to write; fu_ready is ~pending, so a slot refills the cycle after its grant.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int REG_BITS   = WB_REG_BITS,
   parameter int NUM_FU     = WB_NUM_FU,
   parameter int FU_BITS    = WB_FU_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_FU-1:0]            fu_valid,
   output logic [NUM_FU-1:0]            fu_ready,
   input  logic [NUM_FU*REG_BITS-1:0]   fu_dest,
   input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
   input  logic [NUM_FU-1:0]            wb_block,
   output logic                         write_en,
   output logic [REG_BITS-1:0]          write_addr,
   output logic [DATA_WIDTH-1:0]        write_data,
   output logic                         wb_done,
   output logic [FU_BITS-1:0]           wb_fu_id
);

   logic [NUM_FU-1:0]     pending;
   logic [REG_BITS-1:0]   slot_dest [NUM_FU];
   logic [DATA_WIDTH-1:0] slot_data [NUM_FU];
   logic [FU_BITS-1:0]    rr_ptr;
   logic                  grant_valid;
   logic [FU_BITS-1:0]    grant_idx;

   assign fu_ready = ~pending;

   rr_arbiter #(
      .N        (NUM_FU),
      .IDX_BITS (FU_BITS)
   ) u_rr (
      .req         (pending & ~wb_block),
      .ptr         (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Grant and capture never hit the same slot: grant needs pending, capture needs ~pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            slot_dest[i] <= '0;
            slot_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (grant_valid && (grant_idx == FU_BITS'(i))) begin
               pending[i] <= 1'b0;
            end else if (fu_valid[i] && !pending[i]) begin
               pending[i]   <= 1'b1;
               slot_dest[i] <= fu_dest[i*REG_BITS +: REG_BITS];
               slot_data[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         write_en   <= 1'b0;
         wb_done    <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         wb_fu_id   <= '0;
      end else if (grant_valid) begin
         rr_ptr     <= FU_BITS'(rr_wrap(int'(grant_idx) + 1, NUM_FU));
         wb_done    <= 1'b1;
         wb_fu_id   <= grant_idx;
         write_addr <= slot_dest[grant_idx];
         write_data <= slot_data[grant_idx];
         // r0 is hardwired zero: the grant still retires, but nothing is written.
         write_en   <= (slot_dest[grant_idx] != '0);
      end else begin
         write_en   <= 1'b0;
         wb_done    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a shadow register file fed from the write port.
module tb_writeback_arbiter;
   localparam int DW = 32;
   localparam int RB = 5;
   localparam int NF = 4;
   localparam int FB = 2;

   logic             clk;
   logic             rst_n;
   logic [NF-1:0]    fu_valid;
   logic [NF-1:0]    fu_ready;
   logic [NF*RB-1:0] fu_dest;
   logic [NF*DW-1:0] fu_data;
   logic [NF-1:0]    wb_block;
   logic             write_en;
   logic [RB-1:0]    write_addr;
   logic [DW-1:0]    write_data;
   logic             wb_done;
   logic [FB-1:0]    wb_fu_id;

   logic [DW-1:0]    shadow_rf [32];
   int               n_checks;
   int               n_fail;
   int               n_writes;

   writeback_arbiter #(
      .DATA_WIDTH (DW),
      .REG_BITS   (RB),
      .NUM_FU     (NF),
      .FU_BITS    (FB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_dest    (fu_dest),
      .fu_data    (fu_data),
      .wb_block   (wb_block),
      .write_en   (write_en),
      .write_addr (write_addr),
      .write_data (write_data),
      .wb_done    (wb_done),
      .wb_fu_id   (wb_fu_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (write_en) shadow_rf[write_addr] <= write_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [RB-1:0] d, input logic [DW-1:0] v);
      fu_dest[i*RB +: RB] = d;
      fu_data[i*DW +: DW] = v;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [FB-1:0] fair_seq [6];
      n_checks = 0;
      n_fail   = 0;
      n_writes = 0;
      for (int i = 0; i < 32; i++) shadow_rf[i] = '0;
      fu_valid = '0;
      fu_dest  = '0;
      fu_data  = '0;
      wb_block = '0;
      rst_n    = 1'b0;

      // Reset state
      #3;
      check_eq("rst_ready", 64'(fu_ready), 64'hF);
      check_eq("rst_wen", 64'(write_en), 64'h0);
      check_eq("rst_done", 64'(wb_done), 64'h0);
      check_eq("rst_addr", 64'(write_addr), 64'h0);
      check_eq("rst_data", 64'(write_data), 64'h0);
      check_eq("rst_fuid", 64'(wb_fu_id), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single result from FU1
      set_fu(1, 5'd7, 32'hDEADBEEF);
      fu_valid = 4'b0010;
      tick();
      fu_valid = '0;
      check_eq("single_ready_low", 64'(fu_ready), 64'hD);
      check_eq("single_wen_early", 64'(write_en), 64'h0);
      tick();
      check_eq("single_wen", 64'(write_en), 64'h1);
      check_eq("single_done", 64'(wb_done), 64'h1);
      check_eq("single_addr", 64'(write_addr), 64'd7);
      check_eq("single_data", 64'(write_data), 64'hDEADBEEF);
      check_eq("single_fuid", 64'(wb_fu_id), 64'd1);
      check_eq("single_ready_back", 64'(fu_ready), 64'hF);
      tick();
      check_eq("single_wen_drop", 64'(write_en), 64'h0);
      check_eq("single_done_drop", 64'(wb_done), 64'h0);
      check_eq("single_addr_hold", 64'(write_addr), 64'd7);
      check_eq("single_fuid_hold", 64'(wb_fu_id), 64'd1);
      tick();
      check_eq("single_rf7", 64'(shadow_rf[7]), 64'hDEADBEEF);

      // Contention, pointer back at 0
      pulse_reset();
      for (int i = 0; i < NF; i++) set_fu(i, RB'(i + 1), DW'(32'h100 + i));
      fu_valid = 4'b1111;
      tick();
      fu_valid = '0;
      check_eq("cont_ready_all_low", 64'(fu_ready), 64'h0);
      for (int g = 0; g < NF; g++) begin
         tick();
         check_eq("cont_fuid", 64'(wb_fu_id), 64'(g));
         check_eq("cont_addr", 64'(write_addr), 64'(g + 1));
         check_eq("cont_data", 64'(write_data), 64'(32'h100 + g));
         check_eq("cont_ready", 64'(fu_ready), 64'((1 << (g + 1)) - 1));
      end
      tick();
      check_eq("cont_done_end", 64'(wb_done), 64'h0);

      // Fairness: FU0 and FU2 held valid
      fair_seq = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
      set_fu(0, 5'd3, 32'hA0A0A0A0);
      set_fu(2, 5'd4, 32'hC2C2C2C2);
      fu_valid = 4'b0101;
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         check_eq("fair_done", 64'(wb_done), 64'h1);
         check_eq("fair_fuid", 64'(wb_fu_id), 64'(fair_seq[k]));
      end
      fu_valid = '0;
      tick();
      tick();
      tick();
      check_eq("fair_drained", 64'(fu_ready), 64'hF);

      // Blocked slot stays put until release
      wb_block = 4'b1000;
      set_fu(3, 5'd9, 32'hCAFEF00D);
      fu_valid = 4'b1000;
      tick();
      fu_valid = '0;
      n_writes = 0;
      for (int k = 0; k < 5; k++) begin
         if (wb_done || write_en) n_writes++;
         tick();
      end
      check_eq("block_no_write", 64'(n_writes), 64'h0);
      check_eq("block_still_pending", 64'(fu_ready), 64'h7);
      wb_block = '0;
      tick();
      check_eq("block_wen", 64'(write_en), 64'h1);
      check_eq("block_addr", 64'(write_addr), 64'd9);
      check_eq("block_data", 64'(write_data), 64'hCAFEF00D);
      check_eq("block_fuid", 64'(wb_fu_id), 64'd3);

      // Write to r0 retires without a write strobe
      set_fu(2, 5'd0, 32'h55);
      fu_valid = 4'b0100;
      tick();
      fu_valid = '0;
      tick();
      check_eq("r0_done", 64'(wb_done), 64'h1);
      check_eq("r0_fuid", 64'(wb_fu_id), 64'd2);
      check_eq("r0_wen", 64'(write_en), 64'h0);
      tick();
      check_eq("r0_rf0", 64'(shadow_rf[0]), 64'h0);
      check_eq("r0_ready", 64'(fu_ready), 64'hF);

      // Reset with three held results
      wb_block = 4'b0111;
      set_fu(0, 5'd10, 32'h1010);
      set_fu(1, 5'd11, 32'h1111);
      set_fu(2, 5'd12, 32'h1212);
      fu_valid = 4'b0111;
      tick();
      fu_valid = '0;
      check_eq("mid_pending", 64'(fu_ready), 64'h8);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_ready", 64'(fu_ready), 64'hF);
      check_eq("mid_rst_wen", 64'(write_en), 64'h0);
      check_eq("mid_rst_done", 64'(wb_done), 64'h0);
      check_eq("mid_rst_addr", 64'(write_addr), 64'h0);
      check_eq("mid_rst_data", 64'(write_data), 64'h0);
      check_eq("mid_rst_fuid", 64'(wb_fu_id), 64'h0);
      wb_block = '0;
      tick();
      rst_n = 1'b1;
      n_writes = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (wb_done || write_en) n_writes++;
      end
      check_eq("post_rst_no_write", 64'(n_writes), 64'h0);
      check_eq("post_rst_rf10", 64'(shadow_rf[10]), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
